// File: rtl/i2c_slave_regbank_if.sv
// Byte-level handshake between the i2c_slave core and the register bank.
// master: the i2c_slave core (or a bench driving in its place).
// slave : the register bank.
interface i2c_slave_regbank_if;
    logic       busy;
    logic [7:0] rx_data;
    logic       rx_vld;
    logic       tx_req;
    logic [7:0] tx_data;

    modport master (
        output busy, rx_data, rx_vld, tx_req,
        input  tx_data
    );

    modport slave (
        input  busy, rx_data, rx_vld, tx_req,
        output tx_data
    );
endinterface

// File: rtl/i2c_slave_regbank.sv
// Register bank behind the byte interface of i2c_slave.
// Incoming bytes are ADR_BYTES of little-endian register address followed by
// DATA_BYTES-wide little-endian words. Bursts auto-increment the pointer, and
// master reads stream mem[pointer] out byte by byte. A local fabric port gives
// single-cycle-latency read/write access to the same words.
// Optional build macro I2C_REGBANK_WPROT_EN adds input wp: while wp is high,
// I2C writes to addresses >= WP_BASE are dropped.
module i2c_slave_regbank #(
    parameter int ADR_BYTES  = 2,
    parameter int DATA_BYTES = 1,
    parameter int DEPTH      = 256
`ifdef I2C_REGBANK_WPROT_EN
    ,
    parameter int WP_BASE    = DEPTH / 2
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    i2c_slave_regbank_if.slave        bus,
    input  logic [$clog2(DEPTH)-1:0]  loc_adr,
    input  logic                      loc_we,
    input  logic [8*DATA_BYTES-1:0]   loc_wdata,
    output logic [8*DATA_BYTES-1:0]   loc_rdata,
    output logic                      wr_stb,
    output logic [8*ADR_BYTES-1:0]    wr_adr,
    output logic [8*DATA_BYTES-1:0]   wr_data,
    output logic                      err
`ifdef I2C_REGBANK_WPROT_EN
    ,
    input  logic                      wp
`endif
);
    localparam int          AW       = $clog2(DEPTH);
    localparam int          PW       = 8 * ADR_BYTES;
    localparam int          DW       = 8 * DATA_BYTES;
    localparam bit          POW2     = (DEPTH & (DEPTH - 1)) == 0;
    localparam logic [2:0]  ADR_LAST = 3'(ADR_BYTES - 1);
    localparam logic [2:0]  DAT_LAST = 3'(DATA_BYTES - 1);
    localparam logic [32:0] DEPTH_X  = 33'(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_ADR, ST_DATA} state_t;

    state_t          state_q, state_d;
    logic [2:0]      adr_idx_q, adr_idx_d;
    logic [2:0]      dat_idx_q, dat_idx_d;
    logic [2:0]      tx_idx_q, tx_idx_d;
    logic [PW-1:0]   adr_sh_q, adr_sh_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   wr_adr_q, wr_adr_d;
    logic [DW-1:0]   word_sh_q, word_sh_d;
    logic [DW-1:0]   wr_data_q, wr_data_d;
    logic [DW-1:0]   loc_rdata_q, loc_rdata_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            wr_stb_q, wr_stb_d;
    logic            err_q, err_d;
    logic [DW-1:0]   mem_q [DEPTH];

    logic            ptr_in_range, ptr_sat;
    logic [PW-1:0]   ptr_next;
    logic            ptr_load, ptr_inc;
    logic            commit_try, commit_ok, wp_block;
    logic [DW-1:0]   rd_word;

`ifdef I2C_REGBANK_WPROT_EN
    assign wp_block = wp && (33'(ptr_q) >= 33'(WP_BASE));
`else
    assign wp_block = 1'b0;
`endif

    assign rd_word = mem_q[AW'(ptr_q)];

    // Pointer successor: wraps for power-of-two depth, otherwise parks on the
    // first out-of-range value; an already out-of-range pointer stays put.
    always_comb begin
        ptr_in_range = 33'(ptr_q) < DEPTH_X;
        ptr_sat      = 1'b0;
        if (!ptr_in_range) begin
            ptr_next = ptr_q;
        end else if (33'(ptr_q) == DEPTH_X - 33'd1) begin
            if (POW2) begin
                ptr_next = '0;
            end else begin
                ptr_next = PW'(DEPTH);
                ptr_sat  = 1'b1;
            end
        end else begin
            ptr_next = ptr_q + 1'b1;
        end
    end

    // Next-state logic for the byte FSM, read cursor and registered outputs.
    always_comb begin
        state_d     = state_q;
        adr_idx_d   = adr_idx_q;
        dat_idx_d   = dat_idx_q;
        tx_idx_d    = tx_idx_q;
        adr_sh_d    = adr_sh_q;
        word_sh_d   = word_sh_q;
        ptr_d       = ptr_q;
        err_d       = err_q;
        ptr_load    = 1'b0;
        ptr_inc     = 1'b0;
        commit_try  = 1'b0;

        if (!bus.busy) begin
            state_d   = ST_IDLE;
            adr_idx_d = '0;
            dat_idx_d = '0;
            tx_idx_d  = '0;
        end else begin
            if (bus.rx_vld) begin
                case (state_q)
                    ST_IDLE: begin
                        adr_sh_d  = PW'(bus.rx_data);
                        adr_idx_d = 3'd1;
                        dat_idx_d = '0;
                        if (ADR_LAST == 3'd0) begin
                            ptr_load = 1'b1;
                            state_d  = ST_DATA;
                        end else begin
                            state_d  = ST_ADR;
                        end
                    end
                    ST_ADR: begin
                        for (int k = 0; k < ADR_BYTES; k++) begin
                            if (adr_idx_q == 3'(k)) adr_sh_d[8*k +: 8] = bus.rx_data;
                        end
                        if (adr_idx_q == ADR_LAST) begin
                            ptr_load  = 1'b1;
                            state_d   = ST_DATA;
                            dat_idx_d = '0;
                        end else begin
                            adr_idx_d = adr_idx_q + 3'd1;
                        end
                    end
                    ST_DATA: begin
                        for (int k = 0; k < DATA_BYTES; k++) begin
                            if (dat_idx_q == 3'(k)) word_sh_d[8*k +: 8] = bus.rx_data;
                        end
                        if (dat_idx_q == DAT_LAST) begin
                            commit_try = 1'b1;
                            ptr_inc    = 1'b1;
                            dat_idx_d  = '0;
                        end else begin
                            dat_idx_d  = dat_idx_q + 3'd1;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
            if (bus.tx_req) begin
                if (!ptr_in_range) err_d = 1'b1;
                if (tx_idx_q == DAT_LAST) begin
                    tx_idx_d = '0;
                    ptr_inc  = 1'b1;
                end else begin
                    tx_idx_d = tx_idx_q + 3'd1;
                end
            end
        end

        // Write-protected commits still advance the pointer, they just don't land.
        commit_ok = commit_try && ptr_in_range && !wp_block;
        if (commit_try && !ptr_in_range) err_d = 1'b1;

        // A simultaneous write commit and read wrap advance the pointer only once.
        if (ptr_load) begin
            ptr_d = adr_sh_d;
        end else if (ptr_inc) begin
            ptr_d = ptr_next;
            if (ptr_sat) err_d = 1'b1;
        end

        wr_stb_d  = commit_ok;
        wr_adr_d  = commit_ok ? ptr_q : wr_adr_q;
        wr_data_d = commit_ok ? word_sh_d : wr_data_q;

        tx_data_d = 8'hFF;
        if (ptr_in_range) begin
            tx_data_d = rd_word[7:0];
            for (int k = 0; k < DATA_BYTES; k++) begin
                if (tx_idx_q == 3'(k)) tx_data_d = rd_word[8*k +: 8];
            end
        end

        loc_rdata_d = mem_q[loc_adr];
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            adr_idx_q   <= '0;
            dat_idx_q   <= '0;
            tx_idx_q    <= '0;
            adr_sh_q    <= '0;
            word_sh_q   <= '0;
            ptr_q       <= '0;
            err_q       <= 1'b0;
            wr_stb_q    <= 1'b0;
            wr_adr_q    <= '0;
            wr_data_q   <= '0;
            tx_data_q   <= '0;
            loc_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            adr_idx_q   <= adr_idx_d;
            dat_idx_q   <= dat_idx_d;
            tx_idx_q    <= tx_idx_d;
            adr_sh_q    <= adr_sh_d;
            word_sh_q   <= word_sh_d;
            ptr_q       <= ptr_d;
            err_q       <= err_d;
            wr_stb_q    <= wr_stb_d;
            wr_adr_q    <= wr_adr_d;
            wr_data_q   <= wr_data_d;
            tx_data_q   <= tx_data_d;
            loc_rdata_q <= loc_rdata_d;
        end
    end

    // Word storage; the I2C commit is applied last so it wins an address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (loc_we && (33'(loc_adr) < DEPTH_X)) mem_q[loc_adr] <= loc_wdata;
            if (commit_ok) mem_q[AW'(ptr_q)] <= word_sh_d;
        end
    end

    assign bus.tx_data = tx_data_q;
    assign loc_rdata   = loc_rdata_q;
    assign wr_stb      = wr_stb_q;
    assign wr_adr      = wr_adr_q;
    assign wr_data     = wr_data_q;
    assign err         = err_q;
endmodule

// File: doc/i2c_slave_regbank.md
Name: i2c_slave_regbank

Overview:
Synthesisable, parametrised register bank behind the byte-level interface of the existing i2c_slave core. It is the successor to the single-word bench memory model and adds:
- configurable depth and word width;
- auto-incrementing burst reads and writes;
- out-of-range detection;
- a local fabric-side port.

It sits between i2c_slave and user logic in test-system firmware and benches.

Parameters:
ADR_BYTES, 2, register-address bytes received after the device address (1..4)
DATA_BYTES, 1, bytes per register word (1..4)
DEPTH, 256, number of words; valid addresses 0..DEPTH-1
WP_BASE, DEPTH/2, first write-protected address (used only with I2C_REGBANK_WPROT_EN)

Ports:
CLK  in  1  clock
RST  in  1  reset, asynchronous, active-high
BUSY  in  1  i2c_slave transaction active (START seen, STOP not yet)
RX_DATA  in  8  byte written by master
RX_VLD  in  1  one-cycle pulse, RX_DATA valid
TX_REQ  in  1  one-cycle pulse, i2c_slave has latched TX_DATA and wants the next byte
TX_DATA  out  8  byte presented to i2c_slave for master reads
LOC_ADR  in  clog2(DEPTH)  local port address
LOC_WE  in  1  local write enable
LOC_WDATA  in  8*DATA_BYTES  local write data
LOC_RDATA  out  8*DATA_BYTES  local read data
WR_STB  out  1  one-cycle pulse, I2C committed a word
WR_ADR  out  8*ADR_BYTES  address of the committed word
WR_DATA  out  8*DATA_BYTES  committed word
ERR  out  1  sticky: out-of-range access seen; cleared only by RST

Behaviour:
Clock and reset:
- One clock (CLK).
- Reset is asynchronous and active-high (RST).

Reset values:
- All memory words 0; pointer 0.
- TX_DATA 0, LOC_RDATA 0, WR_STB 0, WR_ADR 0, WR_DATA 0, ERR 0.
- FSM in IDLE; byte indices 0.
- RST asserted mid-transaction aborts it immediately; no commit.

Write FSM (advances only on RX_VLD):
- IDLE: first RX_VLD while BUSY=1 -> ADR with adr_idx=1; byte goes to shadow address bits [7:0].
- ADR: bytes are little-endian, so byte k goes to shadow bits [8k+7:8k]. When ADR_BYTES bytes have been received: pointer <= shadow, go to DATA, dat_idx=0.
- DATA:
  - Byte k fills word-shadow bits [8k+7:8k].
  - On byte DATA_BYTES-1, in the same cycle: the word commits to mem[pointer]; WR_STB=1 next cycle with WR_ADR=pointer and WR_DATA=word; pointer increments; dat_idx returns to 0.
  - Pointer wraps from DEPTH-1 to 0 (for DEPTH a power of two; otherwise it saturates at the out-of-range value and ERR sets).
- BUSY=0 in any state -> IDLE in the next cycle:
  - partial address or partial word discarded;
  - pointer retained, so a following read transaction starts at the last set or incremented address (current-address read);
  - tx_idx reset to 0.

Read path:
- TX_DATA = byte tx_idx of mem[pointer], registered and updated 1 cycle after any change of pointer, tx_idx or memory.
- TX_REQ: tx_idx++; on wrap from DATA_BYTES-1, pointer increments (same wrap rule as writes).
- TX_REQ pulses are at least 2 cycles apart.

Out of range (pointer >= DEPTH, possible when 8*ADR_BYTES > clog2(DEPTH)):
- writes are dropped (no WR_STB), reads return 8'hFF, ERR sets.

Local port:
- LOC_RDATA = mem[LOC_ADR], registered, 1-cycle latency.
- LOC_WE writes mem[LOC_ADR].

Simultaneous events:
- I2C commit and LOC_WE to the same address in the same cycle: I2C wins; the local write is lost.
- RX_VLD and TX_REQ in the same cycle: both are processed, but the pointer increments only once.

Optional Feature:
I2C_REGBANK_WPROT_EN:
- Defined:
  - adds input WP (1 bit).
  - While WP=1, I2C commits to addresses >= WP_BASE are dropped: no memory write, no WR_STB.
  - The pointer still increments.
  - The local port is unaffected.
- Undefined: no WP port, no protection logic; all in-range writes commit.

Test Plan:
- Burst write (ADR_BYTES=2, DATA_BYTES=1): write bytes 10,00,AA,BB,CC -> WR_STB three times with WR_ADR 0010/0011/0012 and WR_DATA AA/BB/CC; LOC_ADR=11 gives LOC_RDATA=BB.
- Current-address read: after the write above, BUSY drops; new transaction with 2 address bytes 11,00, BUSY drop, read transaction with 3 TX_REQ pulses -> TX_DATA sequence BB,CC,00.
- Wrap (DEPTH=256): address 00FF, write 5A,A5 -> mem[FF]=5A, mem[00]=A5; pointer ends at 01.
- Partial abort: write address byte 20 only, then BUSY=0 -> no pointer change, no WR_STB, FSM in IDLE; RST asserted mid-DATA -> all outputs 0 immediately.
- Out of range (DEPTH=128): address 0080, write 11 -> no WR_STB, ERR=1; read -> TX_DATA=FF.
- Collision and protection: I2C commit 77 and LOC_WE 33 to the same address in the same cycle -> 77 stored. With I2C_REGBANK_WPROT_EN, WP=1, WP_BASE=80: write to 0090 -> memory unchanged, no WR_STB.
